// File: rtl/dmem_wbuf_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wbuf_if
// Purpose  : M-stage data-memory bus between the datapath and dmem_wbuf:
//            store/load controls, address, store data, load data and the
//            debug doubleword port.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_wbuf_if #(
  parameter int N     = 64,
  parameter int DEPTH = 256
);
  logic                     memwrite;
  logic                     dtype;
  logic [1:0]               ltype;
  logic [N-1:0]             adr;
  logic [N-1:0]             writedata;
  logic [N-1:0]             readdata;
  logic [$clog2(DEPTH)-1:0] checka;
  logic [N-1:0]             check;

  // Datapath side
  modport master (
    output memwrite, dtype, ltype, adr, writedata, checka,
    input  readdata, check
  );

  // Memory side
  modport slave (
    input  memwrite, dtype, ltype, adr, writedata, checka,
    output readdata, check
  );
endinterface
`default_nettype wire

// File: rtl/dmem_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wbuf
// Purpose  : Data memory with a one-entry store buffer. Stores are captured
//            into the buffer and drained into the array on the following
//            edge; loads see buffered bytes through forwarding and are
//            width-selected / extended according to ltype.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_wbuf #(
  parameter int N     = 64,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  dmem_wbuf_if.slave   bus
);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int LANES = N / 8;

  logic [N-1:0]     r_mem [DEPTH];

  logic             r_wbValid;
  logic [IDXW-1:0]  r_wbIdx;
  logic [LANES-1:0] r_wbMask;
  logic [N-1:0]     r_wbData;

  logic [IDXW-1:0]  w_idx;
  logic [2:0]       w_lane;
  logic [LANES-1:0] w_stMask;
  logic [N-1:0]     w_stData;
  logic [N-1:0]     w_ldRaw;
  logic [N-1:0]     w_chkRaw;
  logic [31:0]      w_word;
  logic [7:0]       w_byte;
  logic             w_unusedAdr;

  // Address bits above the index select nothing: addresses wrap.
  assign w_idx       = bus.adr[IDXW+2:3];
  assign w_lane      = bus.adr[2:0];
  assign w_unusedAdr = ^bus.adr[N-1:IDXW+3];

  // Store shaping: doublewords take all lanes, bytes are replicated so the
  // mask alone picks the destination lane.
  always_comb begin
    if (bus.dtype) begin
      w_stMask = '1;
      w_stData = bus.writedata;
    end else begin
      w_stMask = LANES'(1) << w_lane;
      w_stData = {LANES{bus.writedata[7:0]}};
    end
  end

  // Store buffer: captures the current store (or empties) every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wbValid <= 1'b0;
      r_wbIdx   <= '0;
      r_wbMask  <= '0;
      r_wbData  <= '0;
    end else begin
      r_wbValid <= bus.memwrite;
      if (bus.memwrite) begin
        r_wbIdx  <= w_idx;
        r_wbMask <= w_stMask;
        r_wbData <= w_stData;
      end
    end
  end

  // Drain the buffered bytes into the array; contents survive reset, and
  // reset clears r_wbValid so nothing is written while it is high.
  always_ff @(posedge clk) begin
    if (r_wbValid) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_wbMask[k]) begin
          r_mem[r_wbIdx][8*k +: 8] <= r_wbData[8*k +: 8];
        end
      end
    end
  end

  // Merge buffered bytes over the array for the load and debug ports.
  always_comb begin
    w_ldRaw  = r_mem[w_idx];
    w_chkRaw = r_mem[bus.checka];
    for (int k = 0; k < LANES; k++) begin
      if (r_wbValid && (r_wbIdx == w_idx) && r_wbMask[k]) begin
        w_ldRaw[8*k +: 8] = r_wbData[8*k +: 8];
      end
      if (r_wbValid && (r_wbIdx == bus.checka) && r_wbMask[k]) begin
        w_chkRaw[8*k +: 8] = r_wbData[8*k +: 8];
      end
    end
  end

  // Load formatting: word/byte select and sign or zero extension.
  always_comb begin
    w_word = bus.adr[2] ? w_ldRaw[63:32] : w_ldRaw[31:0];
    w_byte = w_ldRaw[8*w_lane +: 8];
    case (bus.ltype)
      2'b00:   bus.readdata = w_ldRaw;
      2'b01:   bus.readdata = {{(N-32){w_word[31]}}, w_word};
      2'b10:   bus.readdata = {{(N-8){w_byte[7]}}, w_byte};
      default: bus.readdata = {{(N-8){1'b0}}, w_byte};
    endcase
  end

  assign bus.check = w_chkRaw;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_wbuf
// Purpose  : Directed self-checking bench for dmem_wbuf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_wbuf;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  dmem_wbuf_if #(.N(64), .DEPTH(256)) bus ();

  dmem_wbuf #(.N(64), .DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic dw);
    bus.memwrite  = 1'b1;
    bus.dtype     = dw;
    bus.adr       = a;
    bus.writedata = d;
    @(posedge clk);
    #1;
    bus.memwrite  = 1'b0;
  endtask

  task automatic idle();
    bus.memwrite = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (dut.r_wbValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wbValid: got %b want 0", dut.r_wbValid);
    end
    checks++;
    if (dut.r_wbMask !== 8'h00) begin
      errors++;
      $display("FAIL reset_wbMask: got %h want 00", dut.r_wbMask);
    end
  endtask

  task automatic test_dword_roundtrip();
    store(64'h40, 64'h0123_4567_89AB_CDEF, 1'b1);
    bus.adr = 64'h40; bus.ltype = 2'b00; bus.checka = 8'd8; #1;
    checks++;
    if (bus.readdata !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL dw_fwd_load: got %h want %h", bus.readdata, 64'h0123_4567_89AB_CDEF);
    end
    checks++;
    if (bus.check !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL dw_fwd_check: got %h want %h", bus.check, 64'h0123_4567_89AB_CDEF);
    end
    idle(); idle();
    checks++;
    if (bus.check !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL dw_array_check: got %h want %h", bus.check, 64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_byte_merge();
    // Upper writedata bits are junk: only writedata[7:0] may land.
    store(64'h43, 64'h1234_5678_9ABC_DEF0, 1'b0);
    bus.adr = 64'h40; bus.ltype = 2'b00; #1;
    checks++;
    if (bus.readdata !== 64'h0123_4567_F0AB_CDEF) begin
      errors++;
      $display("FAIL byte_merge_fwd: got %h want %h", bus.readdata, 64'h0123_4567_F0AB_CDEF);
    end
    bus.adr = 64'h43; bus.ltype = 2'b10; #1;
    checks++;
    if (bus.readdata !== 64'hFFFF_FFFF_FFFF_FFF0) begin
      errors++;
      $display("FAIL byte_signed: got %h want %h", bus.readdata, 64'hFFFF_FFFF_FFFF_FFF0);
    end
    bus.ltype = 2'b11; #1;
    checks++;
    if (bus.readdata !== 64'h0000_0000_0000_00F0) begin
      errors++;
      $display("FAIL byte_unsigned: got %h want %h", bus.readdata, 64'h0000_0000_0000_00F0);
    end
    idle();
    bus.adr = 64'h40; bus.ltype = 2'b00; #1;
    checks++;
    if (bus.readdata !== 64'h0123_4567_F0AB_CDEF) begin
      errors++;
      $display("FAIL byte_merge_array: got %h want %h", bus.readdata, 64'h0123_4567_F0AB_CDEF);
    end
  endtask

  task automatic test_word_select();
    store(64'h80, 64'h8000_0001_7FFF_FFFF, 1'b1);
    bus.adr = 64'h84; bus.ltype = 2'b01; #1;
    checks++;
    if (bus.readdata !== 64'hFFFF_FFFF_8000_0001) begin
      errors++;
      $display("FAIL word_hi: got %h want %h", bus.readdata, 64'hFFFF_FFFF_8000_0001);
    end
    bus.adr = 64'h80; #1;
    checks++;
    if (bus.readdata !== 64'h0000_0000_7FFF_FFFF) begin
      errors++;
      $display("FAIL word_lo: got %h want %h", bus.readdata, 64'h0000_0000_7FFF_FFFF);
    end
    idle();
    bus.adr = 64'h86; #1;
    checks++;
    if (bus.readdata !== 64'hFFFF_FFFF_8000_0001) begin
      errors++;
      $display("FAIL word_hi_unaligned: got %h want %h", bus.readdata, 64'hFFFF_FFFF_8000_0001);
    end
  endtask

  task automatic test_back_to_back();
    store(64'h08, 64'h0, 1'b1);
    idle();
    store(64'h08, 64'h11, 1'b0);
    // Second store presented but not yet clocked: must not forward.
    bus.memwrite = 1'b1; bus.dtype = 1'b0; bus.adr = 64'h09;
    bus.writedata = 64'h22; bus.ltype = 2'b00; #1;
    checks++;
    if (bus.readdata !== 64'h11) begin
      errors++;
      $display("FAIL b2b_pre_edge: got %h want %h", bus.readdata, 64'h11);
    end
    @(posedge clk); #1;
    bus.memwrite = 1'b0; bus.adr = 64'h08; #1;
    checks++;
    if (bus.readdata !== 64'h2211) begin
      errors++;
      $display("FAIL b2b_buffered: got %h want %h", bus.readdata, 64'h2211);
    end
    idle();
    checks++;
    if (bus.readdata !== 64'h2211) begin
      errors++;
      $display("FAIL b2b_drained: got %h want %h", bus.readdata, 64'h2211);
    end
    // Overlapping masks on consecutive edges: the later byte wins.
    store(64'h08, 64'h33, 1'b0);
    store(64'h08, 64'h44, 1'b0);
    bus.adr = 64'h08; bus.ltype = 2'b00; bus.checka = 8'd1; #1;
    checks++;
    if (bus.check !== 64'h2244) begin
      errors++;
      $display("FAIL b2b_overlap_buffered: got %h want %h", bus.check, 64'h2244);
    end
    idle();
    checks++;
    if (bus.readdata !== 64'h2244) begin
      errors++;
      $display("FAIL b2b_overlap_drained: got %h want %h", bus.readdata, 64'h2244);
    end
  endtask

  task automatic test_wrap();
    store(64'h800, 64'hDEAD, 1'b1);
    idle();
    bus.checka = 8'd0; bus.adr = 64'h0; bus.ltype = 2'b00; #1;
    checks++;
    if (bus.check !== 64'hDEAD) begin
      errors++;
      $display("FAIL wrap_check: got %h want %h", bus.check, 64'hDEAD);
    end
    checks++;
    if (bus.readdata !== 64'hDEAD) begin
      errors++;
      $display("FAIL wrap_load: got %h want %h", bus.readdata, 64'hDEAD);
    end
  endtask

  task automatic test_reset_mid_store();
    store(64'h10, 64'hAAAA, 1'b1);
    idle();
    store(64'h10, 64'h5555, 1'b1);
    bus.adr = 64'h10; bus.ltype = 2'b00; bus.checka = 8'd2; #1;
    checks++;
    if (bus.readdata !== 64'h5555) begin
      errors++;
      $display("FAIL rst_pre_fwd: got %h want %h", bus.readdata, 64'h5555);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (dut.r_wbValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_valid: got %b want 0", dut.r_wbValid);
    end
    checks++;
    if (bus.readdata !== 64'hAAAA) begin
      errors++;
      $display("FAIL rst_async_load: got %h want %h", bus.readdata, 64'hAAAA);
    end
    #1 reset = 1'b0;
    idle();
    checks++;
    if (bus.readdata !== 64'hAAAA) begin
      errors++;
      $display("FAIL rst_after_load: got %h want %h", bus.readdata, 64'hAAAA);
    end
    checks++;
    if (bus.check !== 64'hAAAA) begin
      errors++;
      $display("FAIL rst_after_check: got %h want %h", bus.check, 64'hAAAA);
    end
  endtask

  // Test sequence
  initial begin
    clk = 1'b0;
    reset = 1'b1;
    errors = 0;
    checks = 0;
    bus.memwrite  = 1'b0;
    bus.dtype     = 1'b0;
    bus.ltype     = 2'b00;
    bus.adr       = '0;
    bus.writedata = '0;
    bus.checka    = '0;
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    reset = 1'b0;
    idle();
    test_dword_roundtrip();
    test_byte_merge();
    test_word_select();
    test_back_to_back();
    test_wrap();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete, want finish before 100000");
    $fatal(1);
  end
endmodule
`default_nettype wire
